// File: rtl/scurve_pkg.sv
// Shared definitions for the S-curve measurement controller: state encoding,
// header tag and output word width.
package scurve_pkg;

    localparam int WORD_W = 16;
    localparam logic [7:0] HEADER_TAG = 8'hC5;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_LATCH = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_ARM   = S_ARM,
        ST_RUN   = S_RUN,
        ST_LATCH = S_LATCH,
        ST_SEND  = S_SEND,
        ST_DONE  = S_DONE
    } state_t;

    function automatic logic [WORD_W-1:0] make_header(input logic [7:0] chan);
        return {HEADER_TAG, chan};
    endfunction

endpackage

// File: rtl/scurve_hit_counter.sv
// One trigger input: synchronises clk_ext and trigger_n, counts injected pulses
// and the pulse periods that produced at least one trigger.
module scurve_hit_counter
    import scurve_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             reset_n,
    input  logic             clk_ext,
    input  logic             trigger_n,
    input  logic             clear,
    input  logic             enable,
    input  logic             masked,
    input  logic [CNT_W-1:0] cpt_max,
    output logic [CNT_W-1:0] pulse_cnt,
    output logic [CNT_W-1:0] trig_cnt,
    output logic             done
);

    logic [1:0]       ext_sync_r;
    logic             ext_prev_r;
    logic [1:0]       trg_sync_r;
    logic             trg_prev_r;
    logic             hit_flag_r;
    logic [CNT_W-1:0] pulse_cnt_r;
    logic [CNT_W-1:0] trig_cnt_r;
    logic             ext_rise_s;
    logic             trg_fall_s;
    logic             done_s;
    logic             count_en_s;

    // Two-stage synchronisers plus one history flop for edge detection
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            ext_sync_r <= 2'b00;
            ext_prev_r <= 1'b0;
            trg_sync_r <= 2'b00;
            trg_prev_r <= 1'b0;
        end else begin
            ext_sync_r <= {ext_sync_r[0], clk_ext};
            ext_prev_r <= ext_sync_r[1];
            trg_sync_r <= {trg_sync_r[0], trigger_n};
            trg_prev_r <= trg_sync_r[1];
        end
    end

    assign ext_rise_s = ext_sync_r[1] & ~ext_prev_r;
    assign trg_fall_s = trg_prev_r & ~trg_sync_r[1];
    assign done_s     = masked | (pulse_cnt_r == cpt_max);
    assign count_en_s = enable & ~done_s;

    // A trigger is credited to the next pulse edge; at most one hit per period
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_flag_r  <= 1'b0;
            pulse_cnt_r <= '0;
            trig_cnt_r  <= '0;
        end else if (clear | masked) begin
            hit_flag_r  <= 1'b0;
            pulse_cnt_r <= '0;
            trig_cnt_r  <= '0;
        end else if (count_en_s) begin
            if (ext_rise_s) begin
                pulse_cnt_r <= pulse_cnt_r + CNT_W'(1'b1);
                if (hit_flag_r | trg_fall_s) begin
                    trig_cnt_r <= trig_cnt_r + CNT_W'(1'b1);
                    hit_flag_r <= 1'b0;
                end
            end else if (trg_fall_s) begin
                hit_flag_r <= 1'b1;
            end
        end
    end

    assign pulse_cnt = pulse_cnt_r;
    assign trig_cnt  = trig_cnt_r;
    assign done      = done_s;

endmodule

// File: rtl/scurve_multi_trigger_test.sv
// S-curve measurement controller for one channel: runs N_TRIG hit counters and
// streams a tagged result packet into the readout FIFO with backpressure.
module scurve_multi_trigger_test
    import scurve_pkg::*;
#(
    parameter int N_TRIG   = 3,
    parameter int CNT_W    = 16,
    parameter int CHN_ID_W = 6
) (
    input  logic                Clk,
    input  logic                reset_n,
    input  logic                clk_ext,
    input  logic [N_TRIG-1:0]   trigger_n,
    input  logic [N_TRIG-1:0]   trig_mask,
    input  logic                test_start,
    input  logic                test_abort,
    input  logic [CNT_W-1:0]    cpt_max,
    input  logic [CHN_ID_W-1:0] channel_id,
    input  logic                fifo_full,
    output logic [WORD_W-1:0]   scurve_data,
    output logic                scurve_data_wr_en,
    output logic                one_channel_done,
    output logic                test_aborted,
    output logic                test_busy
);

    localparam int MAX_WORDS = 1 + 2 * N_TRIG;
    localparam int IDX_W     = $clog2(MAX_WORDS);
    localparam int DEPTH     = 2 ** IDX_W;
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0] IDX_TWO = IDX_W'(2'd2);

    state_t              state_r;
    logic                start_d_r;
    logic [N_TRIG-1:0]   mask_r;
    logic [CNT_W-1:0]    cpt_max_r;
    logic [CHN_ID_W-1:0] chan_r;
    logic [WORD_W-1:0]   words_r [DEPTH];
    logic [IDX_W-1:0]    idx_r;
    logic [IDX_W-1:0]    last_idx_r;

    logic [CNT_W-1:0]    pulse_cnt_s [N_TRIG];
    logic [CNT_W-1:0]    trig_cnt_s  [N_TRIG];
    logic [N_TRIG-1:0]   done_s;
    logic [WORD_W-1:0]   words_s [DEPTH];
    logic [IDX_W-1:0]    last_idx_s;
    logic [7:0]          chan8_s;
    logic                start_rise_s;
    logic                abort_s;
    logic                cnt_clear_s;
    logic                cnt_run_s;

    assign start_rise_s = test_start & ~start_d_r;
    assign abort_s      = test_abort & (state_r inside {ST_ARM, ST_RUN, ST_LATCH, ST_SEND});
    assign cnt_clear_s  = (state_r == ST_IDLE);
    assign cnt_run_s    = (state_r == ST_RUN);

    for (genvar g = 0; g < N_TRIG; g++) begin : g_trig
        scurve_hit_counter #(
            .CNT_W(CNT_W)
        ) u_hit_counter (
            .Clk       (Clk),
            .reset_n   (reset_n),
            .clk_ext   (clk_ext),
            .trigger_n (trigger_n[g]),
            .clear     (cnt_clear_s),
            .enable    (cnt_run_s),
            .masked    (~mask_r[g]),
            .cpt_max   (cpt_max_r),
            .pulse_cnt (pulse_cnt_s[g]),
            .trig_cnt  (trig_cnt_s[g]),
            .done      (done_s[g])
        );
    end

    // Pack header and the enabled counter pairs into a dense word list
    always_comb begin
        logic [IDX_W-1:0] slot;
        chan8_s                   = '0;
        chan8_s[CHN_ID_W-1:0]     = chan_r;
        slot                      = IDX_ONE;
        for (int j = 0; j < DEPTH; j++) begin
            words_s[j] = '0;
        end
        words_s[0] = make_header(chan8_s);
        for (int i = 0; i < N_TRIG; i++) begin
            if (mask_r[i]) begin
                words_s[slot][CNT_W-1:0]           = pulse_cnt_s[i];
                words_s[slot + IDX_ONE][CNT_W-1:0] = trig_cnt_s[i];
                slot                               = slot + IDX_TWO;
            end else begin
                slot = slot;
            end
        end
        last_idx_s = slot - IDX_ONE;
    end

    // Measurement sequencer with registered outputs; abort overrides every other transition
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r           <= ST_IDLE;
            start_d_r         <= 1'b0;
            mask_r            <= '0;
            cpt_max_r         <= '0;
            chan_r            <= '0;
            words_r           <= '{default: '0};
            idx_r             <= '0;
            last_idx_r        <= '0;
            scurve_data       <= '0;
            scurve_data_wr_en <= 1'b0;
            one_channel_done  <= 1'b0;
            test_aborted      <= 1'b0;
            test_busy         <= 1'b0;
        end else begin
            start_d_r         <= test_start;
            scurve_data_wr_en <= 1'b0;
            one_channel_done  <= 1'b0;
            test_aborted      <= 1'b0;
            if (abort_s) begin
                state_r      <= ST_IDLE;
                test_aborted <= 1'b1;
                test_busy    <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start_rise_s) begin
                            mask_r    <= trig_mask;
                            cpt_max_r <= cpt_max;
                            chan_r    <= channel_id;
                            state_r   <= ST_ARM;
                            test_busy <= 1'b1;
                        end
                    end
                    ST_ARM: begin
                        state_r <= ST_RUN;
                    end
                    ST_RUN: begin
                        if (&done_s) begin
                            state_r <= ST_LATCH;
                        end
                    end
                    ST_LATCH: begin
                        words_r    <= words_s;
                        last_idx_r <= last_idx_s;
                        idx_r      <= '0;
                        state_r    <= ST_SEND;
                    end
                    ST_SEND: begin
                        if (!fifo_full) begin
                            scurve_data       <= words_r[idx_r];
                            scurve_data_wr_en <= 1'b1;
                            if (idx_r == last_idx_r) begin
                                state_r <= ST_DONE;
                            end else begin
                                idx_r <= idx_r + IDX_ONE;
                            end
                        end
                    end
                    ST_DONE: begin
                        one_channel_done <= 1'b1;
                        test_busy        <= 1'b0;
                        state_r          <= ST_IDLE;
                    end
                    default: begin
                        test_busy <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scurve_multi_trigger_test.sv
// Scoreboard bench: stimulus pushes the expected packet, a monitor pops and
// compares every word the controller writes.
module tb_scurve_multi_trigger_test;

    localparam int N_TRIG   = 3;
    localparam int CNT_W    = 16;
    localparam int CHN_ID_W = 6;
    localparam int MAXP     = 128;

    logic                Clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                clk_ext = 1'b0;
    logic [N_TRIG-1:0]   trigger_n = '1;
    logic [N_TRIG-1:0]   trig_mask = '0;
    logic                test_start = 1'b0;
    logic                test_abort = 1'b0;
    logic [CNT_W-1:0]    cpt_max = '0;
    logic [CHN_ID_W-1:0] channel_id = '0;
    logic                fifo_full = 1'b0;
    logic [15:0]         scurve_data;
    logic                scurve_data_wr_en;
    logic                one_channel_done;
    logic                test_aborted;
    logic                test_busy;

    scurve_multi_trigger_test #(
        .N_TRIG(N_TRIG), .CNT_W(CNT_W), .CHN_ID_W(CHN_ID_W)
    ) dut (
        .Clk(Clk), .reset_n(reset_n), .clk_ext(clk_ext), .trigger_n(trigger_n),
        .trig_mask(trig_mask), .test_start(test_start), .test_abort(test_abort),
        .cpt_max(cpt_max), .channel_id(channel_id), .fifo_full(fifo_full),
        .scurve_data(scurve_data), .scurve_data_wr_en(scurve_data_wr_en),
        .one_channel_done(one_channel_done), .test_aborted(test_aborted),
        .test_busy(test_busy)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q [$];
    int          hits_tab [N_TRIG][MAXP];
    int          cyc_n = 0;
    int          stream_words = 0;
    int          first_cyc = 0;
    int          done_cyc = 0;
    int          last_len = 0;
    int          n_done = 0;
    int          n_abort = 0;
    logic        full_seen = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(posedge Clk) begin
        full_seen <= fifo_full;
        cyc_n     <= cyc_n + 1;
    end

    // Monitor: every written word is popped from the scoreboard and compared
    always @(negedge Clk) begin
        if (scurve_data_wr_en) begin
            if (stream_words == 0) first_cyc = cyc_n;
            stream_words++;
            check("wr_while_full", int'(full_seen), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word actual=0x%0h expected=none", scurve_data);
            end else begin
                check("word", int'(scurve_data), int'(exp_q.pop_front()));
            end
        end
        if (one_channel_done) begin
            n_done++;
            done_cyc     = cyc_n;
            last_len     = stream_words;
            stream_words = 0;
        end
        if (test_aborted) begin
            n_abort++;
            stream_words = 0;
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_hits();
        for (int i = 0; i < N_TRIG; i++)
            for (int p = 0; p < MAXP; p++) hits_tab[i][p] = 0;
    endtask

    task automatic random_hits();
        for (int i = 0; i < N_TRIG; i++)
            for (int p = 0; p < MAXP; p++)
                hits_tab[i][p] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0;
    endtask

    // Reference: pulse count is cpt; trigger count is the number of periods with any hit
    task automatic push_expected(input logic [2:0] m, input int cpt, input int chan);
        exp_q.push_back({8'hC5, 8'(chan)});
        for (int i = 0; i < N_TRIG; i++) begin
            if (m[i]) begin
                int h = 0;
                for (int p = 0; p < cpt; p++) if (hits_tab[i][p] > 0) h++;
                exp_q.push_back(16'(cpt));
                exp_q.push_back(16'(h));
            end
        end
    endtask

    task automatic start(input logic [2:0] m, input int cpt, input int chan);
        trig_mask  = m;
        cpt_max    = CNT_W'(cpt);
        channel_id = CHN_ID_W'(chan);
        test_start = 1'b1;
        cyc();
        cyc();
        check("busy_after_start", int'(test_busy), 1);
        test_start = 1'b0;
        trig_mask  = 3'($urandom);
        cpt_max    = CNT_W'($urandom);
        channel_id = CHN_ID_W'($urandom);
        repeat (3) cyc();
    endtask

    task automatic drive_periods(input int nper);
        for (int p = 0; p < nper; p++) begin
            int mx = 0;
            for (int i = 0; i < N_TRIG; i++) if (hits_tab[i][p] > mx) mx = hits_tab[i][p];
            for (int s = 0; s < mx; s++) begin
                for (int i = 0; i < N_TRIG; i++) trigger_n[i] = !(hits_tab[i][p] > s);
                repeat (3) cyc();
                trigger_n = '1;
                repeat (3) cyc();
            end
            clk_ext = 1'b1;
            repeat (4) cyc();
            clk_ext = 1'b0;
            repeat (3) cyc();
        end
    endtask

    // mode 0: FIFO never full; mode 1: full during RUN, then toggled every cycle
    task automatic measure(input logic [2:0] m, input int cpt, input int chan,
                           input int nper, input int mode);
        int d0 = n_done;
        int nw = 1 + 2 * $countones(m);
        push_expected(m, cpt, chan);
        fifo_full = (mode == 1);
        start(m, cpt, chan);
        drive_periods(nper);
        for (int c = 0; c < 400 && n_done == d0; c++) begin
            cyc();
            if (mode == 1) fifo_full = ~fifo_full;
        end
        fifo_full = 1'b0;
        check("done_pulses", n_done - d0, 1);
        check("stream_len", last_len, nw);
        check("queue_drained", exp_q.size(), 0);
        if (mode == 0) check("consecutive_words", done_cyc - first_cyc, nw);
        cyc();
        check("busy_idle", int'(test_busy), 0);
    endtask

    initial begin
        int a0;
        int d0;
        repeat (3) cyc();
        check("rst_data", int'(scurve_data), 0);
        check("rst_wr_en", int'(scurve_data_wr_en), 0);
        check("rst_done", int'(one_channel_done), 0);
        check("rst_aborted", int'(test_aborted), 0);
        check("rst_busy", int'(test_busy), 0);
        reset_n = 1'b1;
        repeat (2) cyc();

        clear_hits();
        for (int p = 0; p < 100; p++) begin
            hits_tab[0][p] = 1;
            hits_tab[1][p] = p % 2;
        end
        measure(3'b111, 100, 5, 100, 0);

        clear_hits();
        hits_tab[1][0] = 3;
        measure(3'b010, 10, 33, 10, 0);

        for (int k = 0; k < 4; k++) begin
            int cpt = $urandom_range(1, 25);
            random_hits();
            measure(3'($urandom), cpt, $urandom_range(0, 63), cpt + $urandom_range(0, 2), 1);
        end

        random_hits();
        a0 = n_abort;
        d0 = n_done;
        start(3'b111, 100, 9);
        drive_periods(40);
        repeat (4) cyc();
        test_abort = 1'b1;
        cyc();
        test_abort = 1'b0;
        repeat (3) cyc();
        check("abort_pulses", n_abort - a0, 1);
        check("abort_no_done", n_done - d0, 0);
        check("abort_busy", int'(test_busy), 0);
        random_hits();
        measure(3'b111, 20, 9, 20, 0);

        measure(3'b111, 0, 12, 0, 0);
        measure(3'b000, 5, 7, 2, 0);

        random_hits();
        push_expected(3'b111, 5, 21);
        fifo_full = 1'b1;
        start(3'b111, 5, 21);
        drive_periods(5);
        fifo_full = 1'b0;
        for (int c = 0; c < 100 && stream_words < 3; c++) begin
            @(posedge Clk);
            #2;
        end
        check("words_before_reset", stream_words, 3);
        reset_n = 1'b0;
        #1;
        check("midrst_data", int'(scurve_data), 0);
        check("midrst_wr_en", int'(scurve_data_wr_en), 0);
        check("midrst_done", int'(one_channel_done), 0);
        check("midrst_aborted", int'(test_aborted), 0);
        check("midrst_busy", int'(test_busy), 0);
        exp_q.delete();
        stream_words = 0;
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (2) cyc();
        random_hits();
        measure(3'b101, 7, 40, 8, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
